keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Front-end that produces the 4-bit digit stream consumed by the combination-lock FSM.
- Scans a 4x4 hex matrix keypad (Pmod KYPD layout) by driving active-low columns and sampling active-low rows.
- Debounces each press and release; emits exactly one single-cycle digit strobe per press.
- Sits between board pins and the lock's digit input.

Parameters:
- SCAN_DIV, 50000, clock cycles each column is driven per scan slot (min 4).
- DEBOUNCE_SCANS, 4, consecutive identical full-scan results required to accept a press or a release (min 1, max 15).
- REPEAT_SCANS, 100, full scans between repeat strobes while a key is held (used only with the optional feature).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- row_n, input, 4, keypad row lines, active-low, asynchronous to clk.
- col_n, output, 4, keypad column drive, one-hot active-low.
- digit, output, 4, hex value of the last accepted key.
- digit_valid, output, 1, one-cycle strobe; digit is valid in this cycle.
- key_down, output, 1, high while a debounced key is held.

Behaviour:
- Reset values: col_n=4'b1110, digit=0, digit_valid=0, key_down=0; all counters 0; FSM in IDLE.
- row_n passes through a 2-flop synchronizer before use.
- Slot counter counts 0..SCAN_DIV-1; column index increments (0->1->2->3->0) when the slot counter wraps. col_n[i]=0 only for the active column i.
- Rows are sampled on the last cycle of each slot (SCAN_DIV-1) to allow settling.
- At the end of column 3's slot, the full-scan result is one of NONE, SINGLE(code), or MULTI (two or more keys).
- A full scan spans 4*SCAN_DIV cycles.
- Key map per column (row0..row3): col0 = 1,4,7,0; col1 = 2,5,8,F; col2 = 3,6,9,E; col3 = A,B,C,D.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB. Evaluation happens only on scan-end cycles; debounce count is 4 bits.
  - IDLE: SINGLE(k) -> latch candidate k, count=1, go to PRESS_DB. If DEBOUNCE_SCANS=1, accept immediately, as below.
  - PRESS_DB, SINGLE(same k): count+1. When count reaches DEBOUNCE_SCANS, accept: go to HELD.
  - PRESS_DB, NONE, MULTI, or a different key: go to IDLE, count=0.
  - Accept action: next cycle, digit<=k, digit_valid=1 for exactly one cycle, key_down<=1.
  - HELD: NONE -> count=1, go to RELEASE_DB. SINGLE or MULTI -> stay in HELD; a key change while held is never reported.
  - RELEASE_DB, NONE: count+1. When count reaches DEBOUNCE_SCANS, key_down<=0 and go to IDLE.
  - RELEASE_DB, any key: go to HELD, count=0.
- digit holds its value between strobes.
- No strobe is possible until a debounced release has occurred.
- Synchronous reset mid-scan or mid-debounce returns everything to reset values on the next edge. No pending strobe survives reset.
- Minimum press-to-strobe latency: DEBOUNCE_SCANS full scans plus 1 cycle, plus 2 synchronizer cycles.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined: in HELD, a repeat counter increments per full scan. When it reaches REPEAT_SCANS, digit_valid pulses again with the held digit and the counter clears. The counter clears on entry to HELD.
- Undefined: one strobe per press only. No repeat counter is synthesized, and REPEAT_SCANS is ignored.

Decomposition:
- Shared package keypad_pkg holds:
  - the FSM state enum;
  - the scan-result type (NONE/SINGLE/MULTI);
  - the 16-entry column/row-to-hex key map constant;
  - the column count constant (4).
- One natural sub-module: keypad_sync2, a 2-flop synchronizer for the 4-bit row bus.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=5, with a behavioural matrix model that pulls row low when its column is driven.
- Reset, no keys -> col_n cycles 1110,1101,1011,0111 every 4 clocks; digit_valid never asserts; key_down=0.
- Hold key '5' (col1,row1) for 10 scans -> exactly one digit_valid with digit=4'h5 after the 3rd full scan; key_down=1; key_down=0 three scans after release.
- Press '9' with bounce (toggle every 3 cycles for 2 scans, then stable) -> a single strobe with digit=4'h9 only after 3 stable scans.
- Hold 'A' and 'D' together -> no strobe. Release 'D' -> strobe with digit=4'hA after 3 scans.
- Assert reset during PRESS_DB of '0' -> no strobe, outputs at reset values. After release, pressing '0' again -> strobe with digit=4'h0.
- With KEYPAD_AUTOREPEAT_EN, hold 'F' for 20 scans -> strobes at accept and then every 5 scans, all with digit=4'hF; without the macro, exactly one strobe.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared types and constants for the 4x4 keypad scanner: FSM state
//             encoding, full-scan result kind, the column/row-to-hex key map
//             and the column count.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int unsigned c_NUM_COLS = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } kp_state_t;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_kind_t;

  // Indexed by {col, row}. Element 0 is the rightmost nibble.
  //   col0 = 1,4,7,0   col1 = 2,5,8,F   col2 = 3,6,9,E   col3 = A,B,C,D
  localparam logic [15:0][3:0] c_KEY_MAP = 64'hDCBA_E963_F852_0741;

  function automatic logic [3:0] key_code(input logic [1:0] col, input logic [1:0] row);
    return c_KEY_MAP[{col, row}];
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner_if
//  Purpose  : Pin-side and digit-side signals of the keypad scanner.
//  Signals  : row_n       - keypad rows, active-low, asynchronous
//             col_n       - column drive, one-hot active-low
//             digit       - hex value of last accepted key
//             digit_valid - one-cycle strobe, digit valid this cycle
//             key_down    - high while a debounced key is held
//  Modports : slave  - the scanner
//             master - the keypad/board and digit consumer
//  Revision : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] digit;
  logic       digit_valid;
  logic       key_down;

  modport slave  (input  row_n, output col_n, output digit, output digit_valid, output key_down);
  modport master (output row_n, input  col_n, input  digit, input  digit_valid, input  key_down);
endinterface
`default_nettype wire

// File: rtl/keypad_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_sync2
//  Purpose  : Two-flop synchronizer for the asynchronous keypad row bus.
//  Ports    : clk   - system clock
//             reset - synchronous active-high reset (flops go to RESET_VAL)
//             i_d   - asynchronous input bus
//             o_q   - synchronized output bus
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_sync2 #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : Scans a 4x4 hex matrix keypad, debounces press and release and
//             emits one single-cycle digit strobe per accepted press.
//  Ports    : clk   - system clock
//             reset - synchronous active-high reset
//             bus   - keypad_scanner_if.slave (row_n, col_n, digit,
//                     digit_valid, key_down)
//  Options  : KEYPAD_AUTOREPEAT_EN - when defined, a held key re-strobes every
//             REPEAT_SCANS full scans; otherwise REPEAT_SCANS is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 100
) (
  input wire logic          clk,
  input wire logic          reset,
  keypad_scanner_if.slave   bus
);

  localparam int unsigned         c_COL_W     = $clog2(c_NUM_COLS);
  localparam int unsigned         c_SLOT_W    = $clog2(SCAN_DIV);
  localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(SCAN_DIV - 1);
  localparam logic [c_COL_W-1:0]  c_COL_LAST  = c_COL_W'(c_NUM_COLS - 1);
  localparam logic [3:0]          c_DB_TARGET = 4'(DEBOUNCE_SCANS);

  logic [c_SLOT_W-1:0] r_slot;
  logic [c_COL_W-1:0]  r_col;
  logic [1:0]          r_acc_cnt;    // keys seen so far this scan, saturates at 2
  logic [3:0]          r_acc_code;
  kp_state_t           r_state;
  logic [3:0]          r_cnt;
  logic [3:0]          r_cand;
  logic [3:0]          r_digit;
  logic                r_valid;
  logic                r_key_down;

  logic [3:0]  w_row_n_sync;
  logic [3:0]  w_hit;
  logic        w_slot_end;
  logic        w_scan_end;
  logic [2:0]  w_col_hits;
  logic [1:0]  w_col_row;
  logic [2:0]  w_sum;
  logic [3:0]  w_code;
  scan_kind_t  w_kind;
  kp_state_t   w_state_nxt;
  logic [3:0]  w_cnt_nxt;
  logic [3:0]  w_cand_nxt;
  logic        w_accept;
  logic        w_release;
  logic        w_repeat;

  keypad_sync2 #(.WIDTH(4), .RESET_VAL(4'hF)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.row_n),
    .o_q   (w_row_n_sync)
  );

  assign w_hit      = ~w_row_n_sync;
  assign w_slot_end = (r_slot == c_SLOT_LAST);
  assign w_scan_end = w_slot_end && (r_col == c_COL_LAST);

  // Column drive and slot timing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot <= '0;
      r_col  <= '0;
    end else if (w_slot_end) begin
      r_slot <= '0;
      r_col  <= r_col + 1'b1;
    end else begin
      r_slot <= r_slot + 1'b1;
    end
  end

  assign bus.col_n = ~(4'b0001 << r_col);

  // Keys in the active column; the lowest row index provides the code.
  always_comb begin
    w_col_hits = 3'd0;
    w_col_row  = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (w_hit[r]) begin
        w_col_hits = w_col_hits + 3'd1;
        w_col_row  = 2'(r);
      end
    end
  end

  // Running total including the current column; only sampled at slot ends.
  assign w_sum  = {1'b0, r_acc_cnt} + w_col_hits;
  assign w_code = (r_acc_cnt != 2'd0) ? r_acc_code : key_code(r_col, w_col_row);

  always_comb begin
    w_kind = SCAN_NONE;
    if (w_sum == 3'd1)     w_kind = SCAN_SINGLE;
    else if (w_sum > 3'd1) w_kind = SCAN_MULTI;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_cnt  <= 2'd0;
      r_acc_code <= 4'd0;
    end else if (w_scan_end) begin
      r_acc_cnt  <= 2'd0;
      r_acc_code <= 4'd0;
    end else if (w_slot_end) begin
      r_acc_cnt  <= (w_sum > 3'd1) ? 2'd2 : w_sum[1:0];
      r_acc_code <= w_code;
    end
  end

  // Debounce FSM: evaluated only on the last cycle of column 3's slot.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    if (w_scan_end) begin
      case (r_state)
        ST_IDLE: begin
          if (w_kind == SCAN_SINGLE) begin
            w_cand_nxt = w_code;
            if (c_DB_TARGET == 4'd1) begin
              w_accept    = 1'b1;
              w_cnt_nxt   = 4'd0;
              w_state_nxt = ST_HELD;
            end else begin
              w_cnt_nxt   = 4'd1;
              w_state_nxt = ST_PRESS_DB;
            end
          end
        end
        ST_PRESS_DB: begin
          if ((w_kind == SCAN_SINGLE) && (w_code == r_cand)) begin
            if (4'(r_cnt + 4'd1) == c_DB_TARGET) begin
              w_accept    = 1'b1;
              w_cnt_nxt   = 4'd0;
              w_state_nxt = ST_HELD;
            end else begin
              w_cnt_nxt = 4'(r_cnt + 4'd1);
            end
          end else begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_HELD: begin
          // Any key activity keeps us here; a key change is never reported.
          if (w_kind == SCAN_NONE) begin
            if (c_DB_TARGET == 4'd1) begin
              w_release   = 1'b1;
              w_cnt_nxt   = 4'd0;
              w_state_nxt = ST_IDLE;
            end else begin
              w_cnt_nxt   = 4'd1;
              w_state_nxt = ST_RELEASE_DB;
            end
          end
        end
        ST_RELEASE_DB: begin
          if (w_kind == SCAN_NONE) begin
            if (4'(r_cnt + 4'd1) == c_DB_TARGET) begin
              w_release   = 1'b1;
              w_cnt_nxt   = 4'd0;
              w_state_nxt = ST_IDLE;
            end else begin
              w_cnt_nxt = 4'(r_cnt + 4'd1);
            end
          end else begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ST_HELD;
          end
        end
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned        c_RPT_W    = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
  localparam logic [c_RPT_W-1:0] c_RPT_LAST = c_RPT_W'(REPEAT_SCANS - 1);

  logic [c_RPT_W-1:0] r_rpt;
  logic               w_stay_held;

  // Counts full scans spent in HELD; any scan that leaves or enters HELD
  // clears it so each hold starts counting from zero.
  assign w_stay_held = w_scan_end && (r_state == ST_HELD) && (w_state_nxt == ST_HELD);
  assign w_repeat    = w_stay_held && (r_rpt == c_RPT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rpt <= '0;
    end else if (w_scan_end) begin
      if (!w_stay_held || (r_rpt == c_RPT_LAST)) r_rpt <= '0;
      else                                       r_rpt <= r_rpt + 1'b1;
    end
  end
`else
  logic w_repeat_unused;
  assign w_repeat        = 1'b0;
  assign w_repeat_unused = (REPEAT_SCANS != 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_cand     <= 4'd0;
      r_digit    <= 4'd0;
      r_valid    <= 1'b0;
      r_key_down <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
      r_valid <= w_accept | w_repeat;
      if (w_accept) begin
        r_digit    <= w_cand_nxt;
        r_key_down <= 1'b1;
      end else if (w_release) begin
        r_key_down <= 1'b0;
      end
    end
  end

  assign bus.digit       = r_digit;
  assign bus.digit_valid = r_valid;
  assign bus.key_down    = r_key_down;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scanner
//  Purpose  : Self-checking bench for keypad_scanner with a behavioural 4x4
//             matrix model (a pressed key pulls its row low while its column
//             is driven) and a strobe scoreboard.
//  Options  : KEYPAD_AUTOREPEAT_EN changes the expected strobe counts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;
  localparam int RPT      = 5;
  localparam int SCAN     = 4 * SCAN_DIV;

  typedef struct {
    int         col;
    int         row;
    logic [3:0] digit;
    int         hold;    // full scans the key is held from the scan start
  } vec_t;

  localparam int NV = 10;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pressed = '0;   // indexed col*4+row
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_strobes = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  mon_exp;
  vec_t        vecs[NV];

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DB),
    .REPEAT_SCANS   (RPT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (kif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    kif.row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && !kif.col_n[c]) kif.row_n[r] = 1'b0;
  end

  // Scoreboard: every strobe must match the oldest expected digit.
  always @(negedge clk) begin
    if (kif.digit_valid) begin
      n_strobes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL strobe_unexpected: got digit=%h at cycle %0d, required no strobe", kif.digit, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (kif.digit !== mon_exp) begin
          n_errors++;
          $display("FAIL strobe_digit: got %h, required %h", kif.digit, mon_exp);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Returns at the negedge of the first cycle of column 0 (slot 0).
  task automatic wait_scan_start();
    int guard;
    guard = 0;
    do begin @(negedge clk); guard++; end while (kif.col_n != 4'b0111 && guard < 64);
    do begin @(negedge clk); guard++; end while (kif.col_n != 4'b1110 && guard < 64);
    if (guard >= 64) begin
      n_checks++;
      n_errors++;
      $display("FAIL scan_align: col_n=%b, required a 0111->1110 transition", kif.col_n);
    end
  endtask

  task automatic wait_strobe(input int bound, output int seen);
    int start;
    start = cyc;
    seen  = -1;
    while (cyc - start < bound) begin
      @(negedge clk);
      if (kif.digit_valid) begin
        seen = cyc;
        break;
      end
    end
    if (seen < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL strobe_timeout: got no strobe in %0d cycles, required one", bound);
    end
  endtask

  initial begin
    int c0, c1, s0, seen, n_exp;

    vecs[0] = '{1, 1, 4'h5, 10};
    vecs[1] = '{0, 3, 4'h0, 4};
    vecs[2] = '{1, 3, 4'hF, 20};
    vecs[3] = '{2, 3, 4'hE, 4};
    vecs[4] = '{0, 2, 4'h7, 5};
    vecs[5] = '{3, 2, 4'hC, 4};
    vecs[6] = '{0, 0, 4'h1, 4};
    vecs[7] = '{3, 1, 4'hB, 4};
    vecs[8] = '{2, 0, 4'h3, 4};
    vecs[9] = '{2, 1, 4'h6, 6};

    // ---- reset values, then idle column rotation
    repeat (3) @(negedge clk);
    check("rst_col_n", kif.col_n, 4'b1110);
    check("rst_digit", kif.digit, 4'h0);
    check("rst_valid", kif.digit_valid, 1'b0);
    check("rst_key_down", kif.key_down, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 32; k++) begin
      check("idle_col_n", kif.col_n, ~(32'h1 << ((k / SCAN_DIV) % 4)) & 32'hF);
      @(negedge clk);
    end
    check("idle_key_down", kif.key_down, 1'b0);
    check("idle_strobes", n_strobes, 0);

    // ---- table-driven single-key presses
    for (int i = 0; i < NV; i++) begin
      wait_scan_start();
      c0 = cyc;
      s0 = n_strobes;
      pressed[vecs[i].col*4 + vecs[i].row] = 1'b1;
      exp_q.push_back(vecs[i].digit);
      wait_strobe(6 * SCAN, seen);
      check("press_latency", seen - c0, DB * SCAN);
      check("key_down_after_accept", kif.key_down, 1'b1);
`ifdef KEYPAD_AUTOREPEAT_EN
      n_exp = 1 + (vecs[i].hold - DB) / RPT;
`else
      n_exp = 1;
`endif
      for (int k = 1; k < n_exp; k++) exp_q.push_back(vecs[i].digit);
      wait_until(c0 + vecs[i].hold * SCAN);
      pressed = '0;
      wait_until(c0 + (vecs[i].hold + DB) * SCAN - 1);
      check("key_down_release_db", kif.key_down, 1'b1);
      @(negedge clk);
      check("key_down_released", kif.key_down, 1'b0);
      check("press_strobe_count", n_strobes - s0, n_exp);
      check("press_queue_empty", exp_q.size(), 0);
    end

    // ---- '9' bouncing for two scans, then stable
    wait_scan_start();
    c0 = cyc;
    s0 = n_strobes;
    for (int k = 0; k < 2 * SCAN; k++) begin
      pressed[10] = ((k / 3) % 2 == 1);
      @(negedge clk);
    end
    pressed[10] = 1'b1;
    exp_q.push_back(4'h9);
    wait_strobe(6 * SCAN, seen);
    check("bounce_latency", seen - c0, 5 * SCAN);
    pressed = '0;
    wait_until(seen + 5 * SCAN);
    check("bounce_strobe_count", n_strobes - s0, 1);
    check("bounce_key_down", kif.key_down, 1'b0);

    // ---- 'A' and 'D' together, then release 'D'
    wait_scan_start();
    c0 = cyc;
    s0 = n_strobes;
    pressed[12] = 1'b1;
    pressed[15] = 1'b1;
    wait_until(c0 + 6 * SCAN);
    check("multi_no_strobe", n_strobes - s0, 0);
    check("multi_key_down", kif.key_down, 1'b0);
    pressed[15] = 1'b0;
    c1 = cyc;
    exp_q.push_back(4'hA);
    wait_strobe(6 * SCAN, seen);
    check("multi_release_latency", seen - c1, DB * SCAN);
    pressed = '0;
    wait_until(seen + 5 * SCAN);
    check("multi_strobe_count", n_strobes - s0, 1);
    check("multi_queue_empty", exp_q.size(), 0);

    // ---- reset while '0' is in press debounce
    wait_scan_start();
    c0 = cyc;
    s0 = n_strobes;
    pressed[3] = 1'b1;
    wait_until(c0 + SCAN + 4);
    reset   = 1'b1;
    pressed = '0;
    @(negedge clk);
    check("midrst_col_n", kif.col_n, 4'b1110);
    check("midrst_digit", kif.digit, 4'h0);
    check("midrst_valid", kif.digit_valid, 1'b0);
    check("midrst_key_down", kif.key_down, 1'b0);
    reset = 1'b0;
    wait_until(cyc + 6 * SCAN);
    check("midrst_no_strobe", n_strobes - s0, 0);
    wait_scan_start();
    c0 = cyc;
    pressed[3] = 1'b1;
    exp_q.push_back(4'h0);
    wait_strobe(6 * SCAN, seen);
    check("repress_latency", seen - c0, DB * SCAN);
    check("repress_digit", kif.digit, 4'h0);
    pressed = '0;
    wait_until(seen + 5 * SCAN);
    check("repress_strobe_count", n_strobes - s0, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
